// File: rtl/drive_arbiter.sv
// Motor drive command arbiter: safety override, auto/manual selection, dwell, reversal gap, valid/ready output.
// Define DRIVE_ARB_MANUAL_EN to build the IR-remote manual path and its timeout counter.
//
// state  | meaning
// IDLE   | safety stop or bot disabled, output forced Stop
// AUTO   | autonomous command owns the output
// MANUAL | latched IR command owns the output until timeout
// GAP    | forced Stop between left/right reversal, then back to originating state
module drive_arbiter #(
    parameter int MIN_DWELL      = 2_500_000,
    parameter int GAP_CYCLES     = 1_250_000,
    parameter int MANUAL_TIMEOUT = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       estop,
    input  logic [2:0] auto_command,
    input  logic       auto_valid,
    input  logic [2:0] manual_command,
    input  logic       manual_valid,
    input  logic       drive_ready,
    output logic [2:0] drive_command,
    output logic       drive_valid,
    output logic [1:0] source,
    output logic       manual_active
);
    localparam int DW_W  = $clog2(MIN_DWELL + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [DW_W-1:0]  DWELL_SAT = DW_W'(MIN_DWELL);
    localparam logic [GAP_W-1:0] GAP_SAT   = GAP_W'(GAP_CYCLES);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [2:0]       STOP      = 3'd0;

    typedef enum logic [1:0] {IDLE, AUTO, MANUAL, GAP} state_t;

    state_t            state, state_nxt, mode;
    logic              ret_manual, ret_manual_nxt;
    logic [2:0]        man_latch, latch_nxt;
    logic [2:0]        cmd_nxt, target, auto_target;
    logic              valid_nxt;
    logic [DW_W-1:0]   dwell_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic              dwell_clr, gap_clr, tmo_clr;
    logic              man_pulse, tmo_done, safety, gap_done;

    function automatic logic [2:0] norm_cmd(input logic [2:0] c);
        return (c > 3'd5) ? STOP : c;
    endfunction

    function automatic logic is_left(input logic [2:0] c);
        return (c == 3'd1) || (c == 3'd2);
    endfunction

    function automatic logic is_right(input logic [2:0] c);
        return (c == 3'd4) || (c == 3'd5);
    endfunction

    assign safety      = estop | ~enable;
    assign auto_target = auto_valid ? norm_cmd(auto_command) : STOP;
    assign gap_done    = (gap_cnt == GAP_LAST);

`ifdef DRIVE_ARB_MANUAL_EN
    localparam int TMO_W = $clog2(MANUAL_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_SAT  = TMO_W'(MANUAL_TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MANUAL_TIMEOUT - 1);

    logic [TMO_W-1:0] tmo_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if (tmo_clr) begin
            tmo_cnt <= '0;
        end else if (state == MANUAL && tmo_cnt != TMO_SAT) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    assign man_pulse     = manual_valid;
    assign tmo_done      = (state == MANUAL) && (tmo_cnt == TMO_LAST);
    assign manual_active = (state == MANUAL) || ((state == GAP) && ret_manual);
`else
    logic unused_manual;
    assign unused_manual = ^{manual_valid, tmo_clr};
    assign man_pulse     = 1'b0;
    assign tmo_done      = 1'b0;
    assign manual_active = 1'b0;
`endif

    // mode is the state acting this cycle: IDLE, timeout and gap exit all evaluate the new owner immediately
    always_comb begin
        state_nxt      = state;
        mode           = state;
        ret_manual_nxt = ret_manual;
        latch_nxt      = man_latch;
        cmd_nxt        = drive_command;
        valid_nxt      = drive_valid & ~drive_ready;
        dwell_clr      = drive_valid & drive_ready;
        gap_clr        = 1'b0;
        tmo_clr        = 1'b0;
        target         = STOP;
        if (safety) begin
            state_nxt      = IDLE;
            ret_manual_nxt = 1'b0;
            latch_nxt      = STOP;
            dwell_clr      = 1'b1;
            gap_clr        = 1'b1;
            tmo_clr        = 1'b1;
            if (drive_command != STOP) begin
                cmd_nxt   = STOP;
                valid_nxt = 1'b1;
            end
        end else begin
            case (state)
                IDLE:    mode = AUTO;
                AUTO:    mode = AUTO;
                MANUAL:  mode = tmo_done ? AUTO : MANUAL;
                GAP:     mode = gap_done ? (ret_manual ? MANUAL : AUTO) : GAP;
                default: mode = IDLE;
            endcase
            if (man_pulse) begin
                latch_nxt = norm_cmd(manual_command);
                tmo_clr   = 1'b1;
                if (mode == GAP) ret_manual_nxt = 1'b1;
                else             mode = MANUAL;
            end
            state_nxt = mode;
            if (mode == AUTO)        target = auto_target;
            else if (mode == MANUAL) target = latch_nxt;
            if ((mode == AUTO || mode == MANUAL) && !drive_valid && target != drive_command) begin
                if ((is_left(target) && is_right(drive_command)) ||
                    (is_right(target) && is_left(drive_command))) begin
                    state_nxt      = GAP;
                    ret_manual_nxt = (mode == MANUAL);
                    gap_clr        = 1'b1;
                    cmd_nxt        = STOP;
                    valid_nxt      = 1'b1;
                end else if (target == STOP || drive_command == STOP || dwell_cnt >= DWELL_SAT) begin
                    cmd_nxt   = target;
                    valid_nxt = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            ret_manual    <= 1'b0;
            man_latch     <= STOP;
            drive_command <= STOP;
            drive_valid   <= 1'b0;
            dwell_cnt     <= '0;
            gap_cnt       <= '0;
        end else begin
            state         <= state_nxt;
            ret_manual    <= ret_manual_nxt;
            man_latch     <= latch_nxt;
            drive_command <= cmd_nxt;
            drive_valid   <= valid_nxt;
            if (dwell_clr) begin
                dwell_cnt <= '0;
            end else if (dwell_cnt != DWELL_SAT) begin
                dwell_cnt <= dwell_cnt + DW_W'(1);
            end
            if (gap_clr) begin
                gap_cnt <= '0;
            end else if (state == GAP && gap_cnt != GAP_SAT) begin
                gap_cnt <= gap_cnt + GAP_W'(1);
            end
        end
    end

    always_comb begin
        source = 2'd0;
        case (state)
            AUTO:    source = 2'd1;
            MANUAL:  source = 2'd2;
            GAP:     source = 2'd3;
            default: source = 2'd0;
        endcase
    end
endmodule

// File: tb/tb_drive_arbiter.sv
// Bench for drive_arbiter: per-cycle vector table through a scoreboard queue, plus async reset sequences.
module tb_drive_arbiter;
    localparam int MIN_DWELL      = 4;
    localparam int GAP_CYCLES     = 3;
    localparam int MANUAL_TIMEOUT = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable, estop, auto_valid, manual_valid, drive_ready;
    logic [2:0] auto_command, manual_command;
    logic [2:0] drive_command;
    logic       drive_valid, manual_active;
    logic [1:0] source;

    drive_arbiter #(
        .MIN_DWELL(MIN_DWELL),
        .GAP_CYCLES(GAP_CYCLES),
        .MANUAL_TIMEOUT(MANUAL_TIMEOUT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .estop(estop),
        .auto_command(auto_command),
        .auto_valid(auto_valid),
        .manual_command(manual_command),
        .manual_valid(manual_valid),
        .drive_ready(drive_ready),
        .drive_command(drive_command),
        .drive_valid(drive_valid),
        .source(source),
        .manual_active(manual_active)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic       en, es, av;
        logic [2:0] ac;
        logic       mv;
        logic [2:0] mc;
        logic       rdy;
        logic [2:0] e_cmd;
        logic       e_val;
        logic [1:0] e_src;
        logic       e_man;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk(input int id, input int en, input int es, input int av, input int ac,
                                input int mv, input int mc, input int rdy,
                                input int ec, input int ev, input int esrc, input int em);
        vec_t v;
        v.id = id; v.en = 1'(en); v.es = 1'(es); v.av = 1'(av); v.ac = 3'(ac);
        v.mv = 1'(mv); v.mc = 3'(mc); v.rdy = 1'(rdy);
        v.e_cmd = 3'(ec); v.e_val = 1'(ev); v.e_src = 2'(esrc); v.e_man = 1'(em);
        return v;
    endfunction

    task automatic add(input int en, input int es, input int av, input int ac, input int mv,
                       input int mc, input int rdy, input int ec, input int ev, input int esrc,
                       input int em);
        vecs.push_back(mk(vecs.size() + 1, en, es, av, ac, mv, mc, rdy, ec, ev, esrc, em));
    endtask

    task automatic check_out(input vec_t v, input string tag);
        n_tests++;
        if (drive_command !== v.e_cmd || drive_valid !== v.e_val ||
            source !== v.e_src || manual_active !== v.e_man) begin
            n_fail++;
            $display("FAIL %s step %0d: cmd/valid/src/man got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                     tag, v.id, drive_command, drive_valid, source, manual_active,
                     v.e_cmd, v.e_val, v.e_src, v.e_man);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        vec_t e;
        enable = v.en; estop = v.es; auto_valid = v.av; auto_command = v.ac;
        manual_valid = v.mv; manual_command = v.mc; drive_ready = v.rdy;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_out(e, tag);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t zero_v;
        enable = 1'b1; estop = 1'b0; auto_valid = 1'b1; auto_command = 3'd3;
        manual_valid = 1'b0; manual_command = 3'd0; drive_ready = 1'b1;
        zero_v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // en es av ac mv mc rdy | cmd val src man
        add(1,0,1,3,0,0,1, 3,1,1,0);                          // first command after reset
        add(1,0,1,3,0,0,1, 3,0,1,0);
        for (int i = 0; i < 4; i++) add(1,0,1,2,0,0,1, 3,0,1,0); // held by dwell
        add(1,0,1,2,0,0,1, 2,1,1,0);
        add(1,0,1,2,0,0,1, 2,0,1,0);
        add(1,0,1,0,0,0,1, 0,1,1,0);                          // to Stop: no dwell
        add(1,0,1,0,0,0,1, 0,0,1,0);
        add(1,0,1,2,0,0,1, 2,1,1,0);                          // from Stop: no dwell
        add(1,0,1,2,0,0,1, 2,0,1,0);
        for (int i = 0; i < 4; i++) add(1,0,1,2,0,0,1, 2,0,1,0);
        add(1,0,1,4,0,0,1, 0,1,3,0);                          // reversal gap
        add(1,0,1,4,0,0,1, 0,0,3,0);
        add(1,0,1,4,0,0,1, 0,0,3,0);
        add(1,0,1,4,0,0,1, 4,1,1,0);
        add(1,0,1,4,0,0,1, 4,0,1,0);
        add(1,0,0,4,0,0,1, 0,1,1,0);                          // auto_valid low = Stop
        add(1,0,1,7,0,0,1, 0,0,1,0);                          // 7 = Stop, equal to current
        add(1,0,1,5,0,0,1, 5,1,1,0);
        add(1,0,1,5,0,0,1, 5,0,1,0);
        for (int i = 0; i < 4; i++) add(1,0,1,5,0,0,1, 5,0,1,0);
        add(1,0,1,3,0,0,1, 3,1,1,0);
        add(1,0,1,3,0,0,1, 3,0,1,0);
        for (int i = 0; i < 4; i++) add(1,0,1,3,0,0,1, 3,0,1,0);
`ifdef DRIVE_ARB_MANUAL_EN
        add(1,0,1,3,1,5,1, 5,1,2,1);                          // manual takeover
        for (int i = 0; i < 19; i++) add(1,0,1,3,0,0,1, 5,0,2,1);
        add(1,0,1,3,1,4,1, 4,1,2,1);                          // pulse on timeout cycle
        for (int i = 0; i < 19; i++) add(1,0,1,3,0,0,1, 4,0,2,1);
        add(1,0,1,3,0,0,1, 3,1,1,0);                          // timeout back to auto
        add(1,0,1,3,0,0,1, 3,0,1,0);
`else
        add(1,0,1,3,1,5,1, 3,0,1,0);                          // manual pulse ignored
        for (int i = 0; i < 19; i++) add(1,0,1,3,0,0,1, 3,0,1,0);
        add(1,0,1,3,1,4,1, 3,0,1,0);
        for (int i = 0; i < 19; i++) add(1,0,1,3,0,0,1, 3,0,1,0);
        add(1,0,1,3,0,0,1, 3,0,1,0);
        add(1,0,1,3,0,0,1, 3,0,1,0);
`endif
        add(1,0,1,0,0,0,1, 0,1,1,0);
        add(1,0,1,0,0,0,1, 0,0,1,0);
        add(1,0,1,3,0,0,0, 3,1,1,0);                          // pending, not ready
        add(1,0,1,1,0,0,0, 3,1,1,0);
        add(1,0,1,1,0,0,0, 3,1,1,0);
        add(1,1,1,1,0,0,0, 0,1,0,0);                          // estop replaces pending
        add(1,1,1,1,0,0,1, 0,0,0,0);
        add(1,0,1,1,0,0,1, 1,1,1,0);
        add(1,0,1,1,0,0,1, 1,0,1,0);
        add(0,0,1,1,0,0,1, 0,1,0,0);                          // disable forces Stop
        add(0,0,1,1,0,0,1, 0,0,0,0);
        add(1,0,1,1,0,0,1, 1,1,1,0);
        add(1,0,1,1,0,0,1, 1,0,1,0);
        add(1,1,1,1,1,5,1, 0,1,0,0);                          // manual pulse with estop dropped
        add(1,0,1,1,0,0,1, 0,0,1,0);                          // Stop still pending this cycle
        add(1,0,1,1,0,0,1, 1,1,1,0);
        add(1,0,1,1,0,0,1, 1,0,1,0);
        add(1,0,1,5,0,0,1, 0,1,3,0);                          // reversal 1 -> 5
        add(1,0,1,5,0,0,1, 0,0,3,0);

        repeat (2) @(negedge clk);
        check_out(zero_v, "reset_values");
        reset = 1'b0;
        foreach (vecs[i]) run_vec(vecs[i], "vec");

        reset = 1'b1;                                          // mid-gap async reset
        #1;
        check_out(zero_v, "reset_mid_gap");
        @(posedge clk);
        #1;
        check_out(zero_v, "reset_held");
        @(negedge clk);
        reset = 1'b0;
        run_vec(mk(101, 1,0,1,5,0,0,1, 5,1,1,0), "after_reset");
        run_vec(mk(102, 1,0,1,5,0,0,0, 5,1,1,0), "pending");
        reset = 1'b1;                                          // mid-handshake async reset
        #1;
        check_out(zero_v, "reset_mid_handshake");
        @(negedge clk);
        reset = 1'b0;
        run_vec(mk(103, 1,0,1,2,0,0,1, 2,1,1,0), "restart");
        run_vec(mk(104, 1,0,1,2,0,0,1, 2,0,1,0), "restart_ack");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/drive_arbiter.md
# drive_arbiter

Arbitrates the motor drive command between the autonomous vision/ultrasonic path and the IR-remote manual path, and sequences changes to the motor controller. It applies safety overrides (e-stop, bot disable), enforces a minimum dwell per command, inserts a forced Stop gap on left/right reversals, and times out stale manual control. It sits between the drive-decision logic and the motor PWM controller, with a valid/ready handshake on its output.

## Interface
- `MIN_DWELL`, 2_500_000: cycles a non-Stop command is held before another non-Stop change is issued.
- `GAP_CYCLES`, 1_250_000: cycles of forced Stop inserted on a left-group/right-group reversal.
- `MANUAL_TIMEOUT`, 50_000_000: cycles without `manual_valid` before manual control lapses.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `enable` in 1: bot-on level; 0 forces Stop.
- `estop` in 1: safety stop level (obstacle too close); 1 forces Stop.
- `auto_command` in 3: autonomous command; encoding 0 Stop, 1 Fast_left, 2 Left, 3 Straight, 4 Right, 5 Fast_right; 6/7 treated as Stop.
- `auto_valid` in 1: `auto_command` is meaningful; 0 is treated as Stop request.
- `manual_command` in 3: IR-decoded command, same encoding.
- `manual_valid` in 1: single-cycle pulse; new manual command.
- `drive_ready` in 1: motor controller accepts `drive_command`.
- `drive_command` out 3: registered arbitrated command.
- `drive_valid` out 1: `drive_command` is a new, unaccepted command.
- `source` out 2: 0 none/safety, 1 auto, 2 manual, 3 gap.
- `manual_active` out 1: manual control currently owns the output.

## Operation
- States: IDLE, AUTO, MANUAL, GAP. Reset -> IDLE.
- Priority each cycle: `reset` > (`estop` | !`enable`) > manual > auto.
- IDLE: target Stop, `source`=0. Leave to AUTO when `enable` & !`estop`.
- Any state: `estop` | !`enable` -> IDLE. Manual latch, dwell counter, and gap counter clear.
- AUTO: target = `auto_command` (Stop if !`auto_valid`). `manual_valid` -> MANUAL, latching `manual_command`.
- MANUAL: target = latched manual command. Each `manual_valid` relatches it and clears the timeout counter. When the counter reaches `MANUAL_TIMEOUT`-1 with no pulse -> AUTO.
- Reversal: if the target is in the left group {1,2} and the current output is in the right group {4,5}, or the reverse, enter GAP. GAP drives Stop for `GAP_CYCLES`, then returns to the originating state (AUTO/MANUAL) and re-evaluates the target.
- Dwell: a change from one non-Stop command to another non-Stop command waits until the dwell counter ≥ `MIN_DWELL`. Changes to Stop and changes from Stop are never delayed by dwell. The dwell counter clears on every accepted change and saturates.
- Handshake: an output change loads `drive_command` and sets `drive_valid`. While `drive_valid` & !`drive_ready`, `drive_command` is held. Pending target changes wait, except a safety Stop, which may replace a pending command.
- `drive_valid` clears on the cycle after `drive_valid` & `drive_ready`.
- No `drive_valid` is issued if the target equals the current `drive_command`.
- Counters are `$clog2(param+1)` bits wide and saturating; they never wrap.

## Timing
- Reset values: `drive_command`=0, `drive_valid`=0, `source`=0, `manual_active`=0.
- Latency: an input change at edge N appears on `drive_command`/`drive_valid` after edge N+1.
- Safety Stop reaches the output in 1 cycle regardless of dwell, gap, or handshake.
- A `manual_valid` coincident with `estop` is discarded.
- A `manual_valid` coincident with the timeout cycle restarts the timeout and stays in MANUAL.
- A `reset` mid-GAP or mid-handshake returns all outputs to their reset values immediately.

## Configuration
- `DRIVE_ARB_MANUAL_EN` defined: manual path is as described.
- `DRIVE_ARB_MANUAL_EN` undefined: `manual_command`/`manual_valid` are ignored, MANUAL is unreachable, and `manual_active` is tied 0. No manual timeout counter is built.

## Test plan
Parameters for all scenarios: `MIN_DWELL`=4, `GAP_CYCLES`=3, `MANUAL_TIMEOUT`=20, `drive_ready`=1 unless stated.
- Release `reset` with `enable`=1, auto=3 -> 1 cycle later `drive_command`=3, `drive_valid` pulses, `source`=1.
- Auto goes 3->2 one cycle after acceptance -> `drive_command` stays 3 until 4 cycles after the change, then becomes 2. Auto 2->0 -> Stop in 1 cycle.
- Auto goes 2->4 after dwell -> 3 cycles of Stop with `source`=3, then `drive_command`=4.
- Manual pulse with cmd 5 while auto=3 -> `drive_command`=5, `manual_active`=1. With no further pulses, after 20 cycles it returns to auto 3.
- Hold `drive_ready`=0 with `drive_command`=3 pending; auto changes to 1 -> output stays 3. Assert `estop` -> `drive_command`=0 next cycle, `source`=0.
- Build with `DRIVE_ARB_MANUAL_EN` undefined and send a manual pulse with cmd 5 -> output unchanged, `manual_active`=0.
